cam_color_detect: RTL and testbench

CAM_COLOR_DETECT -- requirements
Module: cam_color_detect

---
 rtl/cam_pkg.sv | 31 +++
 rtl/px_classify.sv | 51 +++++
 rtl/cam_color_detect.sv | 153 +++++++++++++++
 tb/tb_cam_color_detect.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_pkg                                                         |
// | Purpose  : Shared constants for the camera colour detector: default frame  |
// |            geometry, frame-buffer address width, colour result codes and   |
// |            the detector FSM state encoding.                                |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package cam_pkg;

   // Default frame geometry (QQVGA) and frame-buffer address width
   localparam int CAM_SCREEN_X = 160;
   localparam int CAM_SCREEN_Y = 120;
   localparam int AW           = 15;

   // Colour result codes, also used as the per-pixel class codes
   localparam logic [1:0] COLOR_NONE  = 2'b00;
   localparam logic [1:0] COLOR_RED   = 2'b01;
   localparam logic [1:0] COLOR_GREEN = 2'b10;
   localparam logic [1:0] COLOR_BLUE  = 2'b11;

   // Detector FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DECIDE = 2'd2
   } cam_state_t;

endpackage
`default_nettype wire

// File: rtl/px_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : px_classify                                                     |
// | Purpose  : Purely combinational RGB332 pixel classifier. Expands each      |
// |            channel to 3 bits and reports the channel that leads both       |
// |            others by more than MARGIN, or "none".                          |
// | Ports    : pixel_i [7:0]  RGB332 pixel                                     |
// |            class_o [1:0]  COLOR_NONE / COLOR_RED / COLOR_GREEN / COLOR_BLUE|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module px_classify #(
   parameter int MARGIN = 2
) (
   input  logic [7:0] pixel_i,
   output logic [1:0] class_o
);
   import cam_pkg::*;

   localparam logic [3:0] MARGIN_C = 4'(MARGIN);

   // Channels are zero-extended to 4 bits so that "channel + MARGIN" never wraps.
   // Blue has only 2 source bits; its MSB is replicated into the LSB.
   logic [3:0] red4;
   logic [3:0] grn4;
   logic [3:0] blu4;
   logic       is_red;
   logic       is_grn;
   logic       is_blu;

   assign red4 = {1'b0, pixel_i[7:5]};
   assign grn4 = {1'b0, pixel_i[4:2]};
   assign blu4 = {1'b0, pixel_i[1:0], pixel_i[1]};

   assign is_red = (red4 > (grn4 + MARGIN_C)) && (red4 > (blu4 + MARGIN_C));
   assign is_grn = (grn4 > (red4 + MARGIN_C)) && (grn4 > (blu4 + MARGIN_C));
   assign is_blu = (blu4 > (red4 + MARGIN_C)) && (blu4 > (grn4 + MARGIN_C));

   // At most one of the three flags can be set, so the order is immaterial.
   always_comb begin
      class_o = COLOR_NONE;
      if (is_red) begin
         class_o = COLOR_RED;
      end else if (is_grn) begin
         class_o = COLOR_GREEN;
      end else if (is_blu) begin
         class_o = COLOR_BLUE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cam_color_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_color_detect                                                |
// | Purpose  : Snoops the camera frame-buffer write port, counts red, green    |
// |            and blue pixels over each frame (vsync low) and reports the     |
// |            dominant colour two cycles after vsync rises.                   |
// | Ports    : clk          pixel clock (camera pclk)                          |
// |            rst          asynchronous reset, active low                     |
// |            vsync        camera vertical sync, high = blanking              |
// |            px_wr        frame-buffer write strobe                          |
// |            mem_px_addr  frame-buffer write address [AW-1:0]                |
// |            mem_px_data  RGB332 pixel being written [7:0]                   |
// |            color        last frame result [1:0]                            |
// |            color_valid  one-cycle pulse when color updates                 |
// |            busy         high while a frame is being accumulated            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cam_color_detect #(
   parameter int CAM_SCREEN_X = cam_pkg::CAM_SCREEN_X,
   parameter int CAM_SCREEN_Y = cam_pkg::CAM_SCREEN_Y,
   parameter int AW           = cam_pkg::AW,
   parameter int MARGIN       = 2,
   parameter int MIN_COUNT    = 1920
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vsync,
   input  logic          px_wr,
   input  logic [AW-1:0] mem_px_addr,
   input  logic [7:0]    mem_px_data,
   output logic [1:0]    color,
   output logic          color_valid,
   output logic          busy
);
   import cam_pkg::*;

   localparam logic [31:0]   FRAME_PIX = 32'(CAM_SCREEN_X * CAM_SCREEN_Y);
   localparam logic [AW-1:0] CNT_MAX   = '1;
   localparam logic [AW-1:0] CNT_ONE   = AW'(1);
   localparam logic [AW:0]   MIN_C     = (AW+1)'(MIN_COUNT);

   cam_state_t    state_q;
   logic          vsync_q;
   logic [AW-1:0] cnt_r_q;
   logic [AW-1:0] cnt_g_q;
   logic [AW-1:0] cnt_b_q;
   logic [AW-1:0] cnt_r_d;
   logic [AW-1:0] cnt_g_d;
   logic [AW-1:0] cnt_b_d;
   logic [1:0]    color_q;
   logic [1:0]    color_d;
   logic          color_valid_q;

   logic          vs_fall;
   logic          vs_rise;
   logic          addr_ok;
   logic [1:0]    px_class;
   logic          r_ok;
   logic          g_ok;
   logic          b_ok;

   px_classify #(
      .MARGIN (MARGIN)
   ) u_px_classify (
      .pixel_i (mem_px_data),
      .class_o (px_class)
   );

   // vsync_q resets high so that a line held in blanking over reset release
   // produces no spurious falling edge.
   assign vs_fall = vsync_q & ~vsync;
   assign vs_rise = ~vsync_q & vsync;
   assign addr_ok = 32'(mem_px_addr) < FRAME_PIX;

   // Counter next-state: clear on any falling vsync edge seen in IDLE or
   // ACCUM (the latter restarts a glitched frame); otherwise count valid
   // in-range writes during ACCUM, including one coincident with vsync rising.
   always_comb begin
      cnt_r_d = cnt_r_q;
      cnt_g_d = cnt_g_q;
      cnt_b_d = cnt_b_q;
      if ((state_q == ST_IDLE || state_q == ST_ACCUM) && vs_fall) begin
         cnt_r_d = '0;
         cnt_g_d = '0;
         cnt_b_d = '0;
      end else if (state_q == ST_ACCUM && px_wr && addr_ok) begin
         case (px_class)
            COLOR_RED:   if (cnt_r_q != CNT_MAX) cnt_r_d = cnt_r_q + CNT_ONE;
            COLOR_GREEN: if (cnt_g_q != CNT_MAX) cnt_g_d = cnt_g_q + CNT_ONE;
            COLOR_BLUE:  if (cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + CNT_ONE;
            default:     ;
         endcase
      end
   end

   // Decision: largest qualifying counter wins, ties go red > green > blue.
   // Once red is rejected, green only has to beat blue, and blue only has to
   // qualify: the earlier rejections already imply it is the largest.
   assign r_ok = {1'b0, cnt_r_q} >= MIN_C;
   assign g_ok = {1'b0, cnt_g_q} >= MIN_C;
   assign b_ok = {1'b0, cnt_b_q} >= MIN_C;

   always_comb begin
      color_d = COLOR_NONE;
      if (r_ok && (cnt_r_q >= cnt_g_q) && (cnt_r_q >= cnt_b_q)) begin
         color_d = COLOR_RED;
      end else if (g_ok && (cnt_g_q >= cnt_b_q)) begin
         color_d = COLOR_GREEN;
      end else if (b_ok) begin
         color_d = COLOR_BLUE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         vsync_q       <= 1'b1;
         cnt_r_q       <= '0;
         cnt_g_q       <= '0;
         cnt_b_q       <= '0;
         color_q       <= COLOR_NONE;
         color_valid_q <= 1'b0;
      end else begin
         vsync_q       <= vsync;
         cnt_r_q       <= cnt_r_d;
         cnt_g_q       <= cnt_g_d;
         cnt_b_q       <= cnt_b_d;
         color_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (vs_fall) state_q <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (vs_rise) state_q <= ST_DECIDE;
            end
            ST_DECIDE: begin
               color_q       <= color_d;
               color_valid_q <= 1'b1;
               state_q       <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign color       = color_q;
   assign color_valid = color_valid_q;
   assign busy        = (state_q == ST_ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_cam_color_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cam_color_detect                                             |
// | Purpose  : Self-checking bench for cam_color_detect. A frame-level model   |
// |            predicts color / color_valid / busy every cycle; directed       |
// |            frames add literal checks on the final results.                 |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cam_color_detect;

   localparam int SX   = 160;
   localparam int SY   = 120;
   localparam int NPIX = SX * SY;
   localparam int AWB  = 15;
   localparam int MARG = 2;
   localparam int MINC = 1920;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        vsync = 1'b1;
   logic        px_wr = 1'b0;
   logic [14:0] addr  = '0;
   logic [7:0]  data  = '0;
   logic [1:0]  color;
   logic        color_valid;
   logic        busy;

   always #5 clk = ~clk;

   cam_color_detect #(
      .CAM_SCREEN_X (SX),
      .CAM_SCREEN_Y (SY),
      .AW           (AWB),
      .MARGIN       (MARG),
      .MIN_COUNT    (MINC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vsync       (vsync),
      .px_wr       (px_wr),
      .mem_px_addr (addr),
      .mem_px_data (data),
      .color       (color),
      .color_valid (color_valid),
      .busy        (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      longint     due;
      logic [1:0] c;
   } res_t;

   res_t       pend[$];
   int         m_cnt[3];
   bit         m_open;
   bit         m_prev_v;
   bit         m_fall;
   bit         m_rise;
   int         m_k;
   longint     cyc   = 0;
   longint     blind = -1;
   res_t       m_res;
   logic [1:0] e_color = 2'b00;
   bit         e_valid = 1'b0;
   bit         e_busy  = 1'b0;

   // 0 none, 1 red, 2 green, 3 blue
   function automatic int px_class(input logic [7:0] d);
      int r, g, b;
      r = int'(d[7:5]);
      g = int'(d[4:2]);
      b = int'(d[1:0]) * 2 + int'(d[1]);
      if (r > g + MARG && r > b + MARG) return 1;
      if (g > r + MARG && g > b + MARG) return 2;
      if (b > r + MARG && b > g + MARG) return 3;
      return 0;
   endfunction

   function automatic logic [1:0] decide(input int c0, input int c1, input int c2);
      int c[3];
      int best;
      int pick;
      c[0] = c0; c[1] = c1; c[2] = c2;
      best = -1;
      pick = 0;
      for (int i = 0; i < 3; i++) begin
         if (c[i] >= MINC && c[i] > best) begin
            best = c[i];
            pick = i + 1;
         end
      end
      return 2'(pick);
   endfunction

   // A frame is open from a vsync fall to the next vsync rise. Its result is
   // published one edge after the closing edge; during that edge the detector
   // is deciding and nothing else is looked at.
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         pend.delete();
         m_open   = 1'b0;
         m_prev_v = 1'b1;
         blind    = -1;
         e_color  = 2'b00;
         e_valid  = 1'b0;
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      end else begin
         m_fall  = m_prev_v && !vsync;
         m_rise  = !m_prev_v && vsync;
         e_valid = 1'b0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            e_valid = 1'b1;
            e_color = pend[0].c;
            void'(pend.pop_front());
         end
         if (cyc != blind) begin
            if (m_fall) begin
               m_open = 1'b1;
               for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else if (m_open) begin
               if (px_wr && int'(addr) < NPIX) begin
                  m_k = px_class(data);
                  if (m_k != 0 && m_cnt[m_k-1] < (2**AWB) - 1) m_cnt[m_k-1]++;
               end
               if (m_rise) begin
                  m_open    = 1'b0;
                  blind     = cyc + 1;
                  m_res.due = cyc + 1;
                  m_res.c   = decide(m_cnt[0], m_cnt[1], m_cnt[2]);
                  pend.push_back(m_res);
               end
            end
         end
         m_prev_v = vsync;
      end
      e_busy = m_open;
   end

   // -------------------------------------------------------------- compare
   int valid_seen = 0;

   always @(posedge clk) begin
      #1;
      check("color", 32'(color), 32'(e_color));
      check("color_valid", 32'(color_valid), 32'(e_valid));
      check("busy", 32'(busy), 32'(e_busy));
      if (color_valid === 1'b1) valid_seen++;
   end

   // -------------------------------------------------------------- drivers
   task automatic drive_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         px_wr = 1'b0;
      end
   endtask

   task automatic open_frame();
      @(negedge clk);
      px_wr = 1'b0;
      vsync = 1'b0;
   endtask

   task automatic fill(input logic [7:0] d, input int start, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         px_wr = 1'b1;
         addr  = 15'(start + i);
         data  = d;
      end
   endtask

   // Raise vsync (optionally with a final write), optionally drop it again
   // one cycle later, then check the result on the second edge after.
   task automatic close_frame(input bit pulse, input bit with_px, input logic [7:0] d,
                              input int a, input logic [1:0] exp, input string name);
      @(negedge clk);
      vsync = 1'b1;
      px_wr = with_px;
      addr  = 15'(a);
      data  = d;
      @(negedge clk);
      px_wr = 1'b0;
      if (pulse) vsync = 1'b0;
      @(posedge clk);
      #2;
      check({name, "_valid"}, 32'(color_valid), 32'd1);
      check({name, "_color"}, 32'(color), 32'(exp));
   endtask

   // ------------------------------------------------------------- sequence
   int v0;

   initial begin
      rst   = 1'b0;
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_color", 32'(color), 32'd0);
      check("rst_valid", 32'(color_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_vsync_q", 32'(dut.vsync_q), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      drive_idle(3);
      check("release_valid", 32'(valid_seen), 32'd0);

      // Full red frame
      v0 = valid_seen;
      open_frame();
      drive_idle(2);
      check("s1_busy", 32'(busy), 32'd1);
      fill(8'hE0, 0, NPIX);
      close_frame(1'b0, 1'b0, 8'h00, 0, 2'b01, "s1");
      drive_idle(4);
      check("s1_pulses", 32'(valid_seen - v0), 32'd1);
      check("s1_busy_after", 32'(busy), 32'd0);

      // One green pixel short of the threshold
      open_frame();
      fill(8'h1C, 0, MINC - 1);
      fill(8'h00, MINC - 1, 200);
      close_frame(1'b0, 1'b0, 8'h00, 0, 2'b00, "s2a");
      drive_idle(4);

      // Exactly at threshold; the last green pixel arrives with vsync rising
      open_frame();
      fill(8'h00, 0, 200);
      fill(8'h1C, 200, MINC - 1);
      close_frame(1'b0, 1'b1, 8'h1C, 200 + MINC - 1, 2'b10, "s2b");
      drive_idle(4);

      // Red / blue tie
      open_frame();
      fill(8'hE0, 0, 5000);
      fill(8'h03, 5000, 5000);
      close_frame(1'b0, 1'b0, 8'h00, 0, 2'b01, "s3");
      drive_idle(4);

      // Blue frame with out-of-range red writes
      open_frame();
      fill(8'h03, 0, 4000);
      drive_idle(3);
      fill(8'hE0, NPIX, 1000);
      close_frame(1'b0, 1'b0, 8'h00, 0, 2'b11, "s4");
      drive_idle(2);
      check("s4_cnt_r", 32'(dut.cnt_r_q), 32'd0);
      drive_idle(2);

      // Reset mid-frame, then a full blue frame
      v0 = valid_seen;
      open_frame();
      fill(8'hE0, 0, 10000);
      @(negedge clk);
      rst   = 1'b0;
      px_wr = 1'b0;
      vsync = 1'b1;
      drive_idle(3);
      check("s5_rst_color", 32'(color), 32'd0);
      check("s5_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive_idle(5);
      check("s5_release_busy", 32'(busy), 32'd0);
      check("s5_release_pulses", 32'(valid_seen - v0), 32'd0);
      open_frame();
      fill(8'h03, 0, NPIX);
      close_frame(1'b0, 1'b0, 8'h00, 0, 2'b11, "s5");
      drive_idle(4);
      check("s5_pulses", 32'(valid_seen - v0), 32'd1);

      // Short vsync pulse closing a green frame, then IDLE activity
      v0 = valid_seen;
      open_frame();
      fill(8'h1C, 0, 3000);
      close_frame(1'b1, 1'b0, 8'h00, 0, 2'b10, "s6");
      fill(8'hE0, 0, 50);
      drive_idle(2);
      check("s6_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      vsync = 1'b1;
      drive_idle(10);
      check("s6_rise_busy", 32'(busy), 32'd0);
      check("s6_pulses", 32'(valid_seen - v0), 32'd1);
      check("s6_hold_color", 32'(color), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
